// File: rtl/cache_pkg.sv
// Shared widths, op encoding and helpers for the set-associative cache.
package cache_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int TAG_W_DEF    = 5;
  localparam int INDEX_W_DEF  = 4;
  localparam int OFFSET_W_DEF = 2;
  localparam int WAYS_DEF     = 2;

  // Op code is {cmp, write}
  localparam logic [1:0] OP_ACC_RD = 2'b00;
  localparam logic [1:0] OP_ACC_WR = 2'b01;
  localparam logic [1:0] OP_CMP_RD = 2'b10;
  localparam logic [1:0] OP_CMP_WR = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Tree pseudo-LRU for one set: victim walk and touch update.
module cache_plru
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1,
  parameter int NB    = 1
) (
  input  logic [NB-1:0]    tree_i,
  input  logic [WAY_W-1:0] way_i,
  output logic [WAY_W-1:0] victim_o,
  output logic [NB-1:0]    tree_o
);

  localparam int LVLS = clog2(WAYS);

  int vnode;
  int unode;

  // Heap order: children of node n are 2n+1 (lower) and 2n+2 (upper)
  always_comb begin
    victim_o = '0;
    tree_o   = tree_i;
    vnode    = 0;
    unode    = 0;
    for (int l = 0; l < LVLS; l++) begin
      victim_o[LVLS-1-l] = tree_i[vnode];
      vnode = 2 * vnode + 1 + int'(tree_i[vnode]);
    end
    for (int l = 0; l < LVLS; l++) begin
      tree_o[unode] = ~way_i[LVLS-1-l];
      unode = 2 * unode + 1 + int'(way_i[LVLS-1-l]);
    end
  end

endmodule

// File: rtl/cache_set_assoc.sv
// N-way set-associative cache storage with registered results,
// ack pulse, per-set tree PLRU and victim reporting.
module cache_set_assoc
  import cache_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int INDEX_W  = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int WAYS     = WAYS_DEF,
  parameter int WAY_W    = (WAYS > 1) ? clog2(WAYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] word,
  input  logic                cmp,
  input  logic                write,
  input  logic [TAG_W-1:0]    tag,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                valid_in,
  input  logic [WAY_W-1:0]    way_in,
  output logic                hit,
  output logic                dirty,
  output logic [TAG_W-1:0]    tag_out,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid,
  output logic [WAY_W-1:0]    way_out,
  output logic                ack
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam int NB    = (WAYS > 1) ? WAYS - 1 : 1;

  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS][WORDS];

  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [NB-1:0]   plru_q  [SETS];

  logic [WAYS-1:0]  row_valid;
  logic [WAYS-1:0]  row_dirty;
  logic [WAYS-1:0]  hit_vec;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic             inv_any;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] plru_victim;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] sel_way;
  logic [NB-1:0]    plru_next;

  always_comb begin
    row_valid = valid_q[index];
    row_dirty = dirty_q[index];
    hit_vec   = '0;
    hit_way   = '0;
    inv_any   = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (row_valid[w] && tag_mem[index][w] == tag) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
    // Descending scan so the lowest invalid way wins
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!row_valid[w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    hit_any = |hit_vec;
    victim  = inv_any ? inv_way : plru_victim;
    sel_way = cmp ? (hit_any ? hit_way : victim) : way_in;
  end

  cache_plru #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W),
    .NB    (NB)
  ) u_plru (
    .tree_i   (plru_q[index]),
    .way_i    (sel_way),
    .victim_o (plru_victim),
    .tree_o   (plru_next)
  );

  logic wr_data;
  logic wr_tag;
  logic touch;
  logic set_dirty;

  always_comb begin
    wr_data   = 1'b0;
    wr_tag    = 1'b0;
    touch     = 1'b0;
    set_dirty = 1'b0;
    unique case ({cmp, write})
      OP_CMP_RD: touch = hit_any;
      OP_CMP_WR: begin
        touch     = hit_any;
        wr_data   = hit_any;
        set_dirty = hit_any;
      end
      OP_ACC_RD: touch = 1'b1;
      OP_ACC_WR: begin
        wr_data = 1'b1;
        wr_tag  = 1'b1;
        touch   = 1'b1;
      end
      default: ;
    endcase
  end

  logic [WAYS-1:0] valid_row_d;
  logic [WAYS-1:0] dirty_row_d;
  logic [NB-1:0]   plru_row_d;

  always_comb begin
    valid_row_d = row_valid;
    dirty_row_d = row_dirty;
    plru_row_d  = plru_q[index];
    if (wr_tag) begin
      valid_row_d[sel_way] = valid_in;
      dirty_row_d[sel_way] = 1'b0;
    end
    if (set_dirty) dirty_row_d[sel_way] = 1'b1;
    if (touch) plru_row_d = plru_next;
  end

  logic              hit_q, hit_d;
  logic              dirty_q_o, dirty_d_o;
  logic [TAG_W-1:0]  tag_out_q, tag_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_o_q, valid_o_d;
  logic [WAY_W-1:0]  way_out_q, way_out_d;
  logic              ack_q, ack_d;

  // Outputs hold between requests; they report pre-op state
  always_comb begin
    hit_d      = hit_q;
    dirty_d_o  = dirty_q_o;
    tag_out_d  = tag_out_q;
    data_out_d = data_out_q;
    valid_o_d  = valid_o_q;
    way_out_d  = way_out_q;
    ack_d      = enable;
    if (enable) begin
      hit_d      = cmp & hit_any;
      dirty_d_o  = row_dirty[sel_way];
      tag_out_d  = tag_mem[index][sel_way];
      data_out_d = data_mem[index][sel_way][word];
      valid_o_d  = row_valid[sel_way];
      way_out_d  = sel_way;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '{default: '0};
      dirty_q    <= '{default: '0};
      plru_q     <= '{default: '0};
      hit_q      <= 1'b0;
      dirty_q_o  <= 1'b0;
      tag_out_q  <= '0;
      data_out_q <= '0;
      valid_o_q  <= 1'b0;
      way_out_q  <= '0;
      ack_q      <= 1'b0;
    end else begin
      if (enable) begin
        valid_q[index] <= valid_row_d;
        dirty_q[index] <= dirty_row_d;
        plru_q[index]  <= plru_row_d;
      end
      hit_q      <= hit_d;
      dirty_q_o  <= dirty_d_o;
      tag_out_q  <= tag_out_d;
      data_out_q <= data_out_d;
      valid_o_q  <= valid_o_d;
      way_out_q  <= way_out_d;
      ack_q      <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enable && wr_data) data_mem[index][sel_way][word] <= data_in;
    if (enable && wr_tag) tag_mem[index][sel_way] <= tag;
  end

  assign hit      = hit_q;
  assign dirty    = dirty_q_o;
  assign tag_out  = tag_out_q;
  assign data_out = data_out_q;
  assign valid    = valid_o_q;
  assign way_out  = way_out_q;
  assign ack      = ack_q;

endmodule

// File: doc/cache_set_assoc.md
Name: cache_set_assoc

Overview:
- Parametrised, clocked, N-way set-associative cache storage array; the successor to the direct-mapped single-cycle cache.
- Keeps the same operation model: compare-read, compare-write, access-read and access-write, driven by the cmp/write pair.
- Adds a clock, registered results with an ack pulse, configurable geometry, per-set tree pseudo-LRU replacement and victim-way reporting.
- Sits below the cache controller FSM, which sequences miss handling against memory.

Parameters:
- DATA_W, 16, data word width
- TAG_W, 5, tag width
- INDEX_W, 4, set index width (2**INDEX_W sets)
- OFFSET_W, 2, word-select width (2**OFFSET_W words per line)
- WAYS, 2, associativity; power of two, 1..8
- WAY_W, max(1,clog2(WAYS)), way-select width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  request strobe, sampled each rising edge
- index  in  INDEX_W  set select
- word  in  OFFSET_W  word within line
- cmp  in  1  1 = compare op, 0 = access op
- write  in  1  1 = write op
- tag  in  TAG_W  request tag
- data_in  in  DATA_W  write data
- valid_in  in  1  valid bit stored by access-write
- way_in  in  WAY_W  target way for access ops
- hit  out  1  compare hit
- dirty  out  1  dirty bit of the selected way (pre-op value)
- tag_out  out  TAG_W  tag of the selected way
- data_out  out  DATA_W  word of the selected way (pre-op value)
- valid  out  1  valid bit of the selected way
- way_out  out  WAY_W  selected way (hit way, victim way, or way_in)
- ack  out  1  result-valid pulse

Behaviour:
- Reset (async): all outputs 0; every valid bit, dirty bit and PLRU bit cleared. Tag and data arrays are not reset. A request in flight is discarded; no ack follows.
- Latency: a request sampled at edge N updates state at edge N. Outputs are registered at edge N and valid with ack=1 for exactly the cycle after. Back-to-back requests every cycle are allowed.
- enable=0 at an edge: ack=0 next cycle; other outputs hold their last values; no state change.
- Way selection for compare ops:
  - Hit way = the way with valid=1 and a matching tag. At most one way can hit; controller invariant.
  - On miss, the selected way is the victim: the lowest-numbered invalid way if any, else the way named by PLRU.
- Ops (cmp, write):
  - (1,0) compare-read: hit reported. Outputs come from the selected way. On hit, that way becomes MRU.
  - (1,1) compare-write: on hit, the word is written and dirty set; the way becomes MRU; dirty/data_out report pre-write values. On miss, no state change; victim info is reported.
  - (0,0) access-read: outputs come from way_in; hit=0; way_in becomes MRU.
  - (0,1) access-write: data_in written to word of way_in; tag<=tag, valid<=valid_in, dirty<=0; way_in becomes MRU; outputs report pre-write values; hit=0.
- Ordering: an op sees every state change made by the op accepted one edge earlier (write-then-read to the same set returns the new data).
- PLRU: WAYS-1 tree bits per set, heap order, root = node 0.
  - Victim walk: bit 0 → go to the lower half; bit 1 → go to the upper half.
  - On access to way w, every node on w's path is set to point away from w.
  - WAYS=1: no PLRU state; victim is always way 0.
- Geometry: word selects among 2**OFFSET_W words. No wrap or carry across lines. Indices are unsigned and in range by construction.

Decomposition:
- Shared package cache_pkg holds:
  - default width constants;
  - the op encoding localparams OP_CMP_RD, OP_CMP_WR, OP_ACC_RD, OP_ACC_WR;
  - the clog2 helper.
- One sub-module, cache_plru: combinational victim select and next-state update for one set's tree bits, parametrised by WAYS. The parent holds the per-set PLRU register array.

Test Plan (defaults, WAYS=2):
- Reset, then compare-read index 0, tag 0x1D → next cycle ack=1, hit=0, valid=0, way_out=0, dirty=0.
- Access-write way 0, index 0, word 3, data 0x0F0F, tag 0x1D, valid_in=1; then compare-read of the same address → hit=1, data_out=0x0F0F, dirty=0, way_out=0, tag_out=0x1D.
- Compare-write hit at that address with 0xA5A5 → hit=1, dirty=0; next compare-read → dirty=1, data_out=0xA5A5.
- Fill way 1 at index 0 with tag 0x03, then compare-read tag 0x1D (way 0 becomes MRU), then compare-read tag 0x07 → hit=0, way_out=1, tag_out=0x03, valid=1.
- Compare-write miss with tag 0x07 → hit=0, no state change; a subsequent compare-read of tag 0x1D still hits with data 0xA5A5, dirty=1.
- Assert reset mid-cycle after an enable edge → ack drops to 0 immediately; after release, compare-read of index 0, tag 0x1D → hit=0, valid=0.
